// File: rtl/cu_sched_if.sv
// cu_sched_if: request/grant bundle between the requesters and the cu_sched scheduler
interface cu_sched_if;
    logic [3:0] req;
    logic       done;
    logic       inhibit;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
    modport master (output req, done, inhibit, input gnt, sel, busy, timeout);
    modport slave (input req, done, inhibit, output gnt, sel, busy, timeout);
endinterface

// File: rtl/cu_sched.sv
// cu_sched: round-robin owner of the cu decode select with hold timeout, inhibit and a dead gap.
// Optional CU_SCHED_PRIORITY_EN: requester 0 wins every arbitration without moving the pointer.
module cu_sched #(
    parameter int HOLD_MAX = 15,
    localparam int CNT_W = $clog2(HOLD_MAX + 1)
) (
    input logic clock,
    input logic reset_n,
    cu_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, ptr_nx, win, sel_nx, idx;
    logic [3:0] gnt_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic to_nx, expire, pri, pri_nx;
    // scan ptr+1 last so it wins, giving the ptr+1..ptr order
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k + 1);
            if (bus.req[idx]) win = idx;
        end
`ifdef CU_SCHED_PRIORITY_EN
        if (bus.req[0]) win = 2'd0;
`endif
    end
    assign expire = cnt == CNT_W'(HOLD_MAX - 1);
    always_comb begin
        state_nx = state;
        gnt_nx = bus.gnt;
        sel_nx = bus.sel;
        to_nx = 1'b0;
        cnt_nx = cnt;
        ptr_nx = ptr;
        pri_nx = pri;
        case (state)
            IDLE: if (!bus.inhibit && |bus.req) begin
                gnt_nx = 4'b0001 << win;
                sel_nx = win;
                cnt_nx = '0;
`ifdef CU_SCHED_PRIORITY_EN
                pri_nx = bus.req[0];
`else
                pri_nx = 1'b0;
`endif
                state_nx = GRANT;
            end
            GRANT: if (bus.inhibit || bus.done || !bus.req[bus.sel] || expire) begin
                gnt_nx = 4'b0000;
                to_nx = !bus.inhibit && !bus.done && bus.req[bus.sel];
                ptr_nx = pri ? ptr : bus.sel;
                state_nx = GAP;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            bus.gnt <= '0;
            bus.sel <= '0;
            bus.busy <= 1'b0;
            bus.timeout <= 1'b0;
            cnt <= '0;
            ptr <= 2'd3;
            pri <= 1'b0;
        end else begin
            state <= state_nx;
            bus.gnt <= gnt_nx;
            bus.sel <= sel_nx;
            bus.busy <= |gnt_nx;
            bus.timeout <= to_nx;
            cnt <= cnt_nx;
            ptr <= ptr_nx;
            pri <= pri_nx;
        end
    end
endmodule
